// File: rtl/cpu_bus_responder.sv
// Bus endpoint for the 6502 core: 64 KiB RAM, wait-state insertion on rdy,
// and an I/O page with console FIFO, cycle counter snapshot and exit-code register.
module cpu_bus_responder #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [7:0]  IO_PAGE     = 8'hFE,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [7:0]  POISON      = 8'hAA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ab,
    input  logic [7:0]  cpu_do,
    input  logic        we,
    output logic [7:0]  di,
    output logic        rdy,
    output logic        cons_valid,
    output logic [7:0]  cons_data,
    input  logic        cons_ready,
    output logic        done,
    output logic [7:0]  done_code
);

    localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [WW-1:0] wait_cnt;
    logic [7:0]    rd_data;
    logic [7:0]    io_rdata;
    logic [7:0]    ram_rdata;
    logic [7:0]    ram [0:65535];
    logic [7:0]    fifo_mem [0:FIFO_DEPTH-1];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          overflow;
    logic [15:0]   cycle_cnt;
    logic [7:0]    snapshot;
    logic          accept;
    logic          is_io;
    logic          io_write;
    logic          io_read;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push_req;
    logic          push;
    logic          pop;

    assign rdy        = (wait_cnt == '0);
    assign accept     = rdy;
    assign is_io      = (ab[15:8] == IO_PAGE);
    assign io_write   = accept && we && is_io;
    assign io_read    = accept && !we && is_io;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && cons_ready;
    assign push_req   = io_write && (ab[7:0] == 8'h00);
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign push       = push_req && (!fifo_full || pop);
    assign cons_valid = !fifo_empty;
    assign cons_data  = fifo_mem[rd_ptr[AW-1:0]];
    assign di         = rdy ? rd_data : POISON;
    assign ram_rdata  = ram[ab];

    always_comb begin
        io_rdata = 8'h00;
        case (ab[7:0])
            8'h00:   io_rdata = {overflow, 5'b0, fifo_empty, fifo_full};
            8'h01:   io_rdata = cycle_cnt[7:0];
            8'h02:   io_rdata = snapshot;
            default: io_rdata = 8'h00;
        endcase
    end

    // Every rdy cycle accepts an access; the counter then holds rdy low.
    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= '0;
        else if (accept)
            wait_cnt <= WW'(WAIT_STATES);
        else
            wait_cnt <= wait_cnt - WW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst && accept && we && !is_io)
            ram[ab] <= cpu_do;
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            fifo_mem[wr_ptr[AW-1:0]] <= cpu_do;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data   <= 8'h00;
            overflow  <= 1'b0;
            cycle_cnt <= 16'h0000;
            snapshot  <= 8'h00;
            done      <= 1'b0;
            done_code <= 8'h00;
        end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
            if (accept && !we)
                rd_data <= is_io ? io_rdata : ram_rdata;
            // Status reads return the flag as it was, then clear it.
            if (push_req && !push)
                overflow <= 1'b1;
            else if (io_read && (ab[7:0] == 8'h00))
                overflow <= 1'b0;
            if (io_read && (ab[7:0] == 8'h01))
                snapshot <= cycle_cnt[15:8];
            if (io_write && (ab[7:0] == 8'h03)) begin
                done      <= 1'b1;
                done_code <= cpu_do;
            end
        end
    end

endmodule
